// File: rtl/if_bus_if_if.sv
// Fetch-side memory interface: scratch-pad port plus shared-bus request/grant/ready handshake.
interface if_bus_if_if #(
  parameter int AW = 30,
  parameter int DW = 32
);
  logic [AW-1:0] spm_addr;
  logic          spm_as;
  logic [DW-1:0] spm_rd_data;
  logic          bus_req;
  logic          bus_grnt;
  logic [AW-1:0] bus_addr;
  logic          bus_as;
  logic          bus_rw;
  logic          bus_rdy;
  logic [DW-1:0] bus_rd_data;

  modport master (
    output spm_addr, spm_as,
    input  spm_rd_data,
    output bus_req,
    input  bus_grnt,
    output bus_addr, bus_as, bus_rw,
    input  bus_rdy, bus_rd_data
  );

  modport slave (
    input  spm_addr, spm_as,
    output spm_rd_data,
    input  bus_req,
    output bus_grnt,
    input  bus_addr, bus_as, bus_rw,
    output bus_rdy, bus_rd_data
  );
endinterface

// File: rtl/if_bus_if.sv
// Instruction-fetch bus interface: SPM hits return in-cycle, everything else
// goes over the shared bus with busy stalling the pipeline until data returns.
module if_bus_if #(
  parameter int            AW       = 30,
  parameter int            DW       = 32,
  parameter logic [2:0]    SPM_PAGE = 3'd1,
  parameter logic [DW-1:0] NOP_INSN = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] addr,
  input  logic          stall,
  input  logic          flush,
  output logic          busy,
  output logic [DW-1:0] insn,
  if_bus_if_if.master   bus
);

  typedef enum logic [1:0] {IDLE, REQ, ACCESS, STALL} state_t;

  state_t        state, state_n;
  logic          bus_req_q, bus_req_n;
  logic          bus_as_q, bus_as_n;
  logic [AW-1:0] bus_addr_q, bus_addr_n;
  logic [DW-1:0] rd_buf, rd_buf_n;
  logic          drop, drop_n;

  logic          busy_c;
  logic [DW-1:0] insn_c;
  logic          spm_as_c;
  logic          spm_hit;

  assign spm_hit = (addr[AW-1:AW-3] == SPM_PAGE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      bus_req_q  <= 1'b0;
      bus_as_q   <= 1'b0;
      bus_addr_q <= '0;
      rd_buf     <= '0;
      drop       <= 1'b0;
    end else begin
      state      <= state_n;
      bus_req_q  <= bus_req_n;
      bus_as_q   <= bus_as_n;
      bus_addr_q <= bus_addr_n;
      rd_buf     <= rd_buf_n;
      drop       <= drop_n;
    end
  end

  always_comb begin
    state_n    = state;
    bus_req_n  = bus_req_q;
    bus_as_n   = 1'b0;
    bus_addr_n = bus_addr_q;
    rd_buf_n   = rd_buf;
    drop_n     = drop;
    busy_c     = 1'b0;
    insn_c     = NOP_INSN;
    spm_as_c   = 1'b0;

    case (state)
      IDLE: begin
        if (flush) begin
          state_n = IDLE;
        end else if (spm_hit) begin
          spm_as_c = 1'b1;
          insn_c   = bus.spm_rd_data;
        end else begin
          busy_c    = 1'b1;
          bus_req_n = 1'b1;
          state_n   = REQ;
        end
      end
      REQ: begin
        if (flush) begin
          bus_req_n = 1'b0;
          state_n   = IDLE;
        end else begin
          busy_c = 1'b1;
          if (bus.bus_grnt) begin
            bus_addr_n = addr;
            bus_as_n   = 1'b1;
            state_n    = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (bus.bus_rdy) begin
          insn_c    = (drop | flush) ? NOP_INSN : bus.bus_rd_data;
          bus_req_n = 1'b0;
          rd_buf_n  = bus.bus_rd_data;
          drop_n    = 1'b0;
          state_n   = (stall & !flush & !drop) ? STALL : IDLE;
        end else begin
          busy_c = 1'b1;
          // the bus cycle cannot be aborted, so remember to discard its data
          if (flush) drop_n = 1'b1;
        end
      end
      STALL: begin
        if (flush) begin
          state_n = IDLE;
        end else begin
          insn_c = rd_buf;
          if (!stall) state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // combinational outputs are forced quiet while reset is held
  assign busy   = busy_c & ~reset;
  assign insn   = reset ? NOP_INSN : insn_c;

  assign bus.spm_addr = addr;
  assign bus.spm_as   = spm_as_c & ~reset;
  assign bus.bus_req  = bus_req_q;
  assign bus.bus_as   = bus_as_q;
  assign bus.bus_addr = bus_addr_q;
  assign bus.bus_rw   = 1'b1;

endmodule

// File: tb/tb_if_bus_if.sv
// Directed testbench for if_bus_if: SPM hit, bus fetches, stall, flush and async reset.
module tb_if_bus_if;
  localparam int AW = 30;
  localparam int DW = 32;
  localparam logic [AW-1:0] SPM_A = 30'h0800_0000;
  localparam logic [DW-1:0] NOP   = 32'h0000_0000;
  localparam int S_IDLE = 0, S_REQ = 1, S_ACCESS = 2, S_STALL = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] addr;
  logic          stall, flush;
  logic          busy;
  logic [DW-1:0] insn;

  int n_tests = 0;
  int n_fail  = 0;

  if_bus_if_if #(.AW(AW), .DW(DW)) bif ();

  if_bus_if #(.AW(AW), .DW(DW), .SPM_PAGE(3'd1), .NOP_INSN(32'h0)) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .stall (stall),
    .flush (flush),
    .busy  (busy),
    .insn  (insn),
    .bus   (bif.master)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #2;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_tests++; if (insn !== NOP) begin n_fail++; $display("FAIL reset_insn: got %h expected %h", insn, NOP); end
    n_tests++; if (bif.spm_as !== 1'b0) begin n_fail++; $display("FAIL reset_spm_as: got %b expected 0", bif.spm_as); end
    n_tests++; if (bif.bus_req !== 1'b0) begin n_fail++; $display("FAIL reset_bus_req: got %b expected 0", bif.bus_req); end
    n_tests++; if (bif.bus_as !== 1'b0) begin n_fail++; $display("FAIL reset_bus_as: got %b expected 0", bif.bus_as); end
    n_tests++; if (bif.bus_addr !== 30'h0) begin n_fail++; $display("FAIL reset_bus_addr: got %h expected 0", bif.bus_addr); end
    n_tests++; if (int'(dut.state) !== S_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", int'(dut.state), S_IDLE); end
    tick;
    reset = 1'b0;
  endtask

  task automatic test_spm;
    addr = 30'h0800_0010; stall = 1'b1; bif.spm_rd_data = 32'hDEAD_BEEF;
    #1;
    n_tests++; if (bif.spm_as !== 1'b1) begin n_fail++; $display("FAIL spm_as: got %b expected 1", bif.spm_as); end
    n_tests++; if (insn !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL spm_insn: got %h expected deadbeef", insn); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL spm_busy: got %b expected 0", busy); end
    n_tests++; if (bif.spm_addr !== 30'h0800_0010) begin n_fail++; $display("FAIL spm_addr: got %h expected 08000010", bif.spm_addr); end
    tick;
    stall = 1'b0;
    #1;
    n_tests++; if (bif.bus_req !== 1'b0) begin n_fail++; $display("FAIL spm_no_req: got %b expected 0", bif.bus_req); end
    n_tests++; if (int'(dut.state) !== S_IDLE) begin n_fail++; $display("FAIL spm_state: got %0d expected %0d", int'(dut.state), S_IDLE); end
    tick;
  endtask

  task automatic test_zero_wait;
    addr = 30'h0000_0040;
    #1;
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL zw_busy_c0: got %b expected 1", busy); end
    n_tests++; if (insn !== NOP) begin n_fail++; $display("FAIL zw_insn_c0: got %h expected %h", insn, NOP); end
    n_tests++; if (bif.spm_as !== 1'b0) begin n_fail++; $display("FAIL zw_spm_as: got %b expected 0", bif.spm_as); end
    tick;
    bif.bus_grnt = 1'b1;
    #1;
    n_tests++; if (int'(dut.state) !== S_REQ) begin n_fail++; $display("FAIL zw_state_c1: got %0d expected %0d", int'(dut.state), S_REQ); end
    n_tests++; if (bif.bus_req !== 1'b1) begin n_fail++; $display("FAIL zw_req_c1: got %b expected 1", bif.bus_req); end
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL zw_busy_c1: got %b expected 1", busy); end
    n_tests++; if (bif.bus_as !== 1'b0) begin n_fail++; $display("FAIL zw_as_c1: got %b expected 0", bif.bus_as); end
    n_tests++; if (bif.bus_rw !== 1'b1) begin n_fail++; $display("FAIL zw_rw: got %b expected 1", bif.bus_rw); end
    tick;
    bif.bus_grnt = 1'b0; bif.bus_rdy = 1'b1; bif.bus_rd_data = 32'h1234_5678;
    #1;
    n_tests++; if (bif.bus_as !== 1'b1) begin n_fail++; $display("FAIL zw_as_c2: got %b expected 1", bif.bus_as); end
    n_tests++; if (bif.bus_addr !== 30'h40) begin n_fail++; $display("FAIL zw_bus_addr: got %h expected 40", bif.bus_addr); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL zw_busy_c2: got %b expected 0", busy); end
    n_tests++; if (insn !== 32'h1234_5678) begin n_fail++; $display("FAIL zw_insn_c2: got %h expected 12345678", insn); end
    n_tests++; if (bif.bus_req !== 1'b1) begin n_fail++; $display("FAIL zw_req_c2: got %b expected 1", bif.bus_req); end
    tick;
    bif.bus_rdy = 1'b0; addr = SPM_A;
    #1;
    n_tests++; if (bif.bus_req !== 1'b0) begin n_fail++; $display("FAIL zw_req_c3: got %b expected 0", bif.bus_req); end
    n_tests++; if (bif.bus_as !== 1'b0) begin n_fail++; $display("FAIL zw_as_c3: got %b expected 0", bif.bus_as); end
    n_tests++; if (int'(dut.state) !== S_IDLE) begin n_fail++; $display("FAIL zw_state_c3: got %0d expected %0d", int'(dut.state), S_IDLE); end
    tick;
  endtask

  task automatic test_wait_states;
    int busy_cnt = 0;
    int as_cnt = 0;
    addr = 30'h0000_0044;
    for (int c = 0; c <= 6; c++) begin
      bif.bus_grnt = (c == 3);
      bif.bus_rdy  = (c == 6);
      bif.bus_rd_data = (c == 6) ? 32'hA5A5_0003 : 32'h0;
      #1;
      if (busy === 1'b1) busy_cnt++;
      if (bif.bus_as === 1'b1) as_cnt++;
      n_tests++; if (bif.bus_req !== (c >= 1)) begin n_fail++; $display("FAIL ws_req_c%0d: got %b expected %b", c, bif.bus_req, (c >= 1)); end
      if (c == 6) begin
        n_tests++; if (insn !== 32'hA5A5_0003) begin n_fail++; $display("FAIL ws_insn: got %h expected a5a50003", insn); end
        n_tests++; if (bif.bus_addr !== 30'h44) begin n_fail++; $display("FAIL ws_bus_addr: got %h expected 44", bif.bus_addr); end
      end
      tick;
    end
    bif.bus_rdy = 1'b0; bif.bus_grnt = 1'b0; addr = SPM_A;
    #1;
    n_tests++; if (busy_cnt !== 6) begin n_fail++; $display("FAIL ws_busy_cycles: got %0d expected 6", busy_cnt); end
    n_tests++; if (as_cnt !== 1) begin n_fail++; $display("FAIL ws_as_cycles: got %0d expected 1", as_cnt); end
    n_tests++; if (bif.bus_req !== 1'b0) begin n_fail++; $display("FAIL ws_req_after: got %b expected 0", bif.bus_req); end
    tick;
  endtask

  task automatic test_stall;
    addr = 30'h0000_0080;
    #1;
    tick;
    bif.bus_grnt = 1'b1;
    #1;
    tick;
    bif.bus_grnt = 1'b0; bif.bus_rdy = 1'b1; bif.bus_rd_data = 32'hCAFE_0001; stall = 1'b1;
    #1;
    n_tests++; if (insn !== 32'hCAFE_0001) begin n_fail++; $display("FAIL st_insn_rdy: got %h expected cafe0001", insn); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL st_busy_rdy: got %b expected 0", busy); end
    tick;
    bif.bus_rdy = 1'b0; bif.bus_rd_data = 32'hBAD0_BAD0;
    for (int s = 0; s < 4; s++) begin
      stall = (s < 3);
      if (s == 3) addr = SPM_A;
      #1;
      n_tests++; if (int'(dut.state) !== S_STALL) begin n_fail++; $display("FAIL st_state_s%0d: got %0d expected %0d", s, int'(dut.state), S_STALL); end
      n_tests++; if (insn !== 32'hCAFE_0001) begin n_fail++; $display("FAIL st_insn_s%0d: got %h expected cafe0001", s, insn); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL st_busy_s%0d: got %b expected 0", s, busy); end
      tick;
    end
    #1;
    n_tests++; if (int'(dut.state) !== S_IDLE) begin n_fail++; $display("FAIL st_state_end: got %0d expected %0d", int'(dut.state), S_IDLE); end
    n_tests++; if (bif.bus_req !== 1'b0) begin n_fail++; $display("FAIL st_req_end: got %b expected 0", bif.bus_req); end
    tick;
    n_tests++; if (bif.bus_req !== 1'b0) begin n_fail++; $display("FAIL st_req_end2: got %b expected 0", bif.bus_req); end
  endtask

  task automatic test_flush_access;
    addr = 30'h0000_00C0;
    #1;
    tick;
    bif.bus_grnt = 1'b1;
    #1;
    tick;
    bif.bus_grnt = 1'b0; flush = 1'b1;
    #1;
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL fa_busy_a0: got %b expected 1", busy); end
    n_tests++; if (insn !== NOP) begin n_fail++; $display("FAIL fa_insn_a0: got %h expected %h", insn, NOP); end
    tick;
    flush = 1'b0;
    #1;
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL fa_busy_a1: got %b expected 1", busy); end
    n_tests++; if (dut.drop !== 1'b1) begin n_fail++; $display("FAIL fa_drop_set: got %b expected 1", dut.drop); end
    tick;
    bif.bus_rdy = 1'b1; bif.bus_rd_data = 32'hFFFF_FFFF;
    #1;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL fa_busy_rdy: got %b expected 0", busy); end
    n_tests++; if (insn !== NOP) begin n_fail++; $display("FAIL fa_insn_rdy: got %h expected %h", insn, NOP); end
    tick;
    bif.bus_rdy = 1'b0; addr = SPM_A;
    #1;
    n_tests++; if (int'(dut.state) !== S_IDLE) begin n_fail++; $display("FAIL fa_state: got %0d expected %0d", int'(dut.state), S_IDLE); end
    n_tests++; if (bif.bus_req !== 1'b0) begin n_fail++; $display("FAIL fa_req: got %b expected 0", bif.bus_req); end
    n_tests++; if (dut.drop !== 1'b0) begin n_fail++; $display("FAIL fa_drop_clr: got %b expected 0", dut.drop); end
    tick;
  endtask

  task automatic test_flush_req;
    addr = 30'h0000_0100;
    #1;
    tick;
    flush = 1'b1; bif.bus_grnt = 1'b1;
    #1;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL fr_busy: got %b expected 0", busy); end
    n_tests++; if (bif.bus_req !== 1'b1) begin n_fail++; $display("FAIL fr_req_before: got %b expected 1", bif.bus_req); end
    tick;
    flush = 1'b0; bif.bus_grnt = 1'b0; addr = SPM_A;
    #1;
    n_tests++; if (bif.bus_req !== 1'b0) begin n_fail++; $display("FAIL fr_req_after: got %b expected 0", bif.bus_req); end
    n_tests++; if (bif.bus_as !== 1'b0) begin n_fail++; $display("FAIL fr_no_as: got %b expected 0", bif.bus_as); end
    n_tests++; if (int'(dut.state) !== S_IDLE) begin n_fail++; $display("FAIL fr_state: got %0d expected %0d", int'(dut.state), S_IDLE); end
    tick;
  endtask

  task automatic test_flush_idle;
    addr = 30'h0000_0140; flush = 1'b1;
    #1;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL fi_busy: got %b expected 0", busy); end
    n_tests++; if (insn !== NOP) begin n_fail++; $display("FAIL fi_insn: got %h expected %h", insn, NOP); end
    tick;
    flush = 1'b0; addr = SPM_A;
    #1;
    n_tests++; if (bif.bus_req !== 1'b0) begin n_fail++; $display("FAIL fi_req: got %b expected 0", bif.bus_req); end
    n_tests++; if (int'(dut.state) !== S_IDLE) begin n_fail++; $display("FAIL fi_state: got %0d expected %0d", int'(dut.state), S_IDLE); end
    tick;
  endtask

  task automatic test_async_reset;
    addr = 30'h0000_0180;
    #1;
    tick;
    bif.bus_grnt = 1'b1;
    #1;
    tick;
    bif.bus_grnt = 1'b0;
    #1;
    n_tests++; if (bif.bus_as !== 1'b1) begin n_fail++; $display("FAIL ar_as_pre: got %b expected 1", bif.bus_as); end
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ar_busy_pre: got %b expected 1", busy); end
    reset = 1'b1;
    #1;
    n_tests++; if (bif.bus_req !== 1'b0) begin n_fail++; $display("FAIL ar_req: got %b expected 0", bif.bus_req); end
    n_tests++; if (bif.bus_as !== 1'b0) begin n_fail++; $display("FAIL ar_as: got %b expected 0", bif.bus_as); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ar_busy: got %b expected 0", busy); end
    n_tests++; if (insn !== NOP) begin n_fail++; $display("FAIL ar_insn: got %h expected %h", insn, NOP); end
    n_tests++; if (int'(dut.state) !== S_IDLE) begin n_fail++; $display("FAIL ar_state: got %0d expected %0d", int'(dut.state), S_IDLE); end
    addr = SPM_A;
    tick;
    reset = 1'b0;
    #1;
    n_tests++; if (bif.bus_req !== 1'b0) begin n_fail++; $display("FAIL ar_req_release: got %b expected 0", bif.bus_req); end
    n_tests++; if (int'(dut.state) !== S_IDLE) begin n_fail++; $display("FAIL ar_state_release: got %0d expected %0d", int'(dut.state), S_IDLE); end
    tick;
  endtask

  initial begin
    addr = SPM_A; stall = 1'b0; flush = 1'b0;
    bif.bus_grnt = 1'b0; bif.bus_rdy = 1'b0; bif.bus_rd_data = '0; bif.spm_rd_data = '0;
    test_reset;
    test_spm;
    test_zero_wait;
    test_wait_states;
    test_stall;
    test_flush_access;
    test_flush_req;
    test_flush_idle;
    test_async_reset;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
